riscv_dmem: RTL



---
 rtl/riscv_dmem.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/riscv_dmem.sv
// Data-memory responder for the hart: byte-addressable RAM plus an MMIO block
// holding the 64-bit machine timer and the external-interrupt synchroniser.
module riscv_dmem #(
  parameter int          RAM_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000,
  parameter int          TIMER_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [2:0]  mem_op,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        ext_irq,
  output logic        timer_irq,
  output logic        hardware_irq
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;

  logic [31:0]   r_mem [RAM_WORDS];
  logic [63:0]   r_mtime;
  logic [63:0]   r_mtimecmp;
  logic [PW-1:0] r_presc;
  logic          r_match_q;
  logic          r_timer_irq;
  logic          r_ext_p0;
  logic          r_ext_p1;
  logic          r_ext_p2;
  logic          r_hw_irq;

  logic [1:0]    w_size;
  logic          w_store;
  logic          w_misal;
  logic          w_ok;
  logic          w_wr;
  logic          w_rd;
  logic          w_ram_hit;
  logic          w_mmio_hit;
  logic [AW-1:0] w_widx;
  logic [3:0]    w_be;
  logic [31:0]   w_wlane;
  logic [31:0]   w_ram_word;
  logic [31:0]   w_mmio_word;
  logic [31:0]   w_sel_word;
  logic [31:0]   w_shifted;
  logic          w_mmio_wr;
  logic          w_wr_mtlo;
  logic          w_wr_mthi;
  logic          w_wr_cmplo;
  logic          w_wr_cmphi;
  logic          w_tick;
  logic          w_match;

  assign w_size     = mem_op[1:0];
  assign w_store    = mem_op[2];
  assign w_misal    = ((w_size == 2'd2) & addr[0]) | ((w_size == 2'd3) & (|addr[1:0]));
  assign w_ok       = (|w_size) & ~w_misal;
  assign w_wr       = w_ok & w_store;
  assign w_rd       = w_ok & ~w_store;
  assign w_ram_hit  = (addr[31:AW+2] == '0);
  assign w_mmio_hit = (addr[31:4] == MMIO_BASE[31:4]);
  assign w_widx     = addr[AW+1:2];

  always_comb begin
    w_be    = 4'b0000;
    w_wlane = wdata;
    case (w_size)
      2'd1: begin
        w_be    = 4'b0001 << addr[1:0];
        w_wlane = {4{wdata[7:0]}};
      end
      2'd2: begin
        w_be    = addr[1] ? 4'b1100 : 4'b0011;
        w_wlane = {2{wdata[15:0]}};
      end
      2'd3: w_be = 4'b1111;
      default: w_be = 4'b0000;
    endcase
  end

  // RAM has no reset; a store coinciding with rst is dropped whole.
  always_ff @(posedge clk) begin
    if (!rst && w_wr && w_ram_hit) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_widx][8*i +: 8] <= w_wlane[8*i +: 8];
      end
    end
  end

  assign w_ram_word = r_mem[w_widx];

  always_comb begin
    w_mmio_word = 32'd0;
    case (addr[3:2])
      2'd0: w_mmio_word = r_mtime[31:0];
      2'd1: w_mmio_word = r_mtime[63:32];
      2'd2: w_mmio_word = r_mtimecmp[31:0];
      2'd3: w_mmio_word = r_mtimecmp[63:32];
      default: w_mmio_word = 32'd0;
    endcase
  end

  always_comb begin
    w_sel_word = 32'd0;
    if (w_ram_hit)       w_sel_word = w_ram_word;
    else if (w_mmio_hit) w_sel_word = w_mmio_word;
    w_shifted = w_sel_word >> {addr[1:0], 3'b000};
    rdata     = 32'd0;
    if (w_rd) begin
      case (w_size)
        2'd1:    rdata = {24'd0, w_shifted[7:0]};
        2'd2:    rdata = {16'd0, w_shifted[15:0]};
        default: rdata = w_shifted;
      endcase
    end
  end

  // Only aligned word stores reach the timer registers.
  assign w_mmio_wr  = w_wr & w_mmio_hit & (w_size == 2'd3);
  assign w_wr_mtlo  = w_mmio_wr & (addr[3:2] == 2'd0);
  assign w_wr_mthi  = w_mmio_wr & (addr[3:2] == 2'd1);
  assign w_wr_cmplo = w_mmio_wr & (addr[3:2] == 2'd2);
  assign w_wr_cmphi = w_mmio_wr & (addr[3:2] == 2'd3);

  assign w_tick = (r_presc == PW'(TIMER_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc <= '0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + PW'(1);
    end
  end

  // A software write to one half beats the tick; the other half holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mtime <= 64'd0;
    end else if (w_wr_mtlo) begin
      r_mtime[31:0] <= wdata;
    end else if (w_wr_mthi) begin
      r_mtime[63:32] <= wdata;
    end else if (w_tick) begin
      r_mtime <= r_mtime + 64'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mtimecmp <= '1;
    end else begin
      if (w_wr_cmplo) r_mtimecmp[31:0]  <= wdata;
      if (w_wr_cmphi) r_mtimecmp[63:32] <= wdata;
    end
  end

  assign w_match = (r_mtime >= r_mtimecmp);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_match_q   <= 1'b0;
      r_timer_irq <= 1'b0;
    end else begin
      r_match_q   <= w_match;
      r_timer_irq <= w_match & ~r_match_q;
    end
  end

  // Two-flop synchroniser followed by a registered rising-edge detect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ext_p0 <= 1'b0;
      r_ext_p1 <= 1'b0;
      r_ext_p2 <= 1'b0;
      r_hw_irq <= 1'b0;
    end else begin
      r_ext_p0 <= ext_irq;
      r_ext_p1 <= r_ext_p0;
      r_ext_p2 <= r_ext_p1;
      r_hw_irq <= r_ext_p1 & ~r_ext_p2;
    end
  end

  assign timer_irq    = r_timer_irq;
  assign hardware_irq = r_hw_irq;

endmodule
